// File: rtl/iiitb_rc_pkg.sv
// iiitb_rc_pkg: shared types, widths and the generator feedback rule
// for the rc sequence checker.
package iiitb_rc_pkg;

  localparam int LFSR_W = 4;
  localparam int PER_W  = 5;

  localparam logic [PER_W-1:0] PER_MAX = '1;

  typedef enum logic [1:0] {
    ST_ACQ,
    ST_TRACK,
    ST_LOCK
  } rc_state_e;

  function automatic logic [LFSR_W-1:0] lfsr_next(
    input logic [LFSR_W-1:0] p
  );
    return {p[0] ^ p[1], p[3], p[2], p[1]};
  endfunction

endpackage

// File: rtl/iiitb_rc_period.sv
// iiitb_rc_period: measures how many enabled samples pass before the
// sample seen at lock entry recurs; saturates and restarts at PER_MAX.
module iiitb_rc_period
  import iiitb_rc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              run,
  input  logic [LFSR_W-1:0] sample,
  output logic [PER_W-1:0]  period,
  output logic              period_valid
);

  logic [LFSR_W-1:0] anchor_q, anchor_d;
  logic [PER_W-1:0]  cnt_q, cnt_d;
  logic [PER_W-1:0]  per_q, per_d;
  logic              vld_q, vld_d;
  logic [PER_W-1:0]  cnt_inc;

  always_comb begin
    anchor_d = anchor_q;
    cnt_d    = cnt_q;
    per_d    = per_q;
    vld_d    = 1'b0;
    cnt_inc  = cnt_q + 1'b1;
    if (start) begin
      anchor_d = sample;
      cnt_d    = '0;
    end else if (run) begin
      if (sample == anchor_q || cnt_inc == PER_MAX) begin
        per_d = cnt_inc;
        vld_d = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anchor_q <= '0;
      cnt_q    <= '0;
      per_q    <= '0;
      vld_q    <= 1'b0;
    end else begin
      anchor_q <= anchor_d;
      cnt_q    <= cnt_d;
      per_q    <= per_d;
      vld_q    <= vld_d;
    end
  end

  assign period       = per_q;
  assign period_valid = vld_q;

endmodule

// File: rtl/iiitb_rc_checker.sv
// iiitb_rc_checker: tracks a 4-bit LFSR stream for lock, mismatches, lock-up.
// Period meter is built when IIITB_RC_CHK_PERIOD_EN is defined.
module iiitb_rc_checker
  import iiitb_rc_pkg::*;
#(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 2,
  parameter int ERR_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [LFSR_W-1:0] in,
  input  logic              clear,
  output logic              locked,
  output logic              mismatch,
  output logic [ERR_W-1:0]  err_count,
  output logic              zero_stuck,
  output logic [PER_W-1:0]  period,
  output logic              period_valid
);

  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
  localparam logic [3:0] LOSS_N = 4'(LOSS_COUNT);

  rc_state_e         state_q, state_d;
  logic [LFSR_W-1:0] prev_q, prev_d;
  logic [3:0]        match_q, match_d;
  logic [3:0]        miss_q, miss_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              mis_q, mis_d;
  logic              zero_q, zero_d;
  logic [LFSR_W-1:0] pred;
  logic [ERR_W-1:0]  err_inc;
  logic              is_zero;
  logic              hit;

  assign pred    = lfsr_next(prev_q);
  assign is_zero = (in == '0);
  assign hit     = (in == pred) && !is_zero;
  assign err_inc = (err_q == '1) ? err_q : err_q + 1'b1;

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    match_d = match_q;
    miss_d  = miss_q;
    err_d   = err_q;
    zero_d  = zero_q;
    mis_d   = 1'b0;
    if (clear) begin
      state_d = ST_ACQ;
      err_d   = '0;
      match_d = '0;
      miss_d  = '0;
    end else if (en) begin
      prev_d = in;
      zero_d = is_zero;
      unique case (state_q)
        ST_TRACK, ST_LOCK: begin
          unique case (1'b1)
            is_zero: begin
              mis_d   = 1'b1;
              err_d   = err_inc;
              state_d = ST_ACQ;
            end
            hit: begin
              if (state_q == ST_LOCK) begin
                miss_d = '0;
              end else begin
                match_d = match_q + 1'b1;
                if (match_d == LOCK_N) begin
                  state_d = ST_LOCK;
                  miss_d  = '0;
                end
              end
            end
            default: begin
              mis_d = 1'b1;
              err_d = err_inc;
              if (state_q == ST_LOCK) begin
                miss_d = miss_q + 1'b1;
                if (miss_d == LOSS_N) begin
                  state_d = ST_TRACK;
                  match_d = '0;
                end
              end else begin
                match_d = '0;
              end
            end
          endcase
        end
        default: begin
          if (!is_zero) begin
            state_d = ST_TRACK;
            match_d = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_ACQ;
      prev_q  <= '0;
      match_q <= '0;
      miss_q  <= '0;
      err_q   <= '0;
      mis_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      match_q <= match_d;
      miss_q  <= miss_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
      zero_q  <= zero_d;
    end
  end

  assign locked     = (state_q == ST_LOCK);
  assign mismatch   = mis_q;
  assign err_count  = err_q;
  assign zero_stuck = zero_q;

`ifdef IIITB_RC_CHK_PERIOD_EN
  logic take, per_start, per_run;

  // Only samples that stay inside LOCK advance the meter.
  assign take      = en && !clear;
  assign per_start = take && state_q != ST_LOCK && state_d == ST_LOCK;
  assign per_run   = take && state_q == ST_LOCK && state_d == ST_LOCK;

  iiitb_rc_period u_period (
    .clk          (clk),
    .rst_n        (reset),
    .start        (per_start),
    .run          (per_run),
    .sample       (in),
    .period       (period),
    .period_valid (period_valid)
  );
`else
  assign period       = '0;
  assign period_valid = 1'b0;
`endif

endmodule

// File: tb/tb_iiitb_rc_checker.sv
// tb_iiitb_rc_checker: directed and randomized checks of the rc checker
// against a behavioural sequence model.
module tb_iiitb_rc_checker;

  localparam int LOCK_COUNT = 4;
  localparam int LOSS_COUNT = 2;
  localparam int ERR_W      = 8;
`ifdef IIITB_RC_CHK_PERIOD_EN
  localparam bit PER_ON = 1'b1;
`else
  localparam bit PER_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] in_v = 4'd0;
  logic       locked, mismatch, zero_stuck, period_valid;
  logic [7:0] err_count;
  logic [4:0] period;

  int n_cmp = 0;
  int n_bad = 0;

  bit m_acq, m_lock, m_mis, m_zero, m_pv;
  int m_prev, m_match, m_miss, m_err, m_per, m_ref, m_pcnt;

  always #5 clk = ~clk;

  iiitb_rc_checker #(
    .LOCK_COUNT (LOCK_COUNT),
    .LOSS_COUNT (LOSS_COUNT),
    .ERR_W      (ERR_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .in           (in_v),
    .clear        (clear),
    .locked       (locked),
    .mismatch     (mismatch),
    .err_count    (err_count),
    .zero_stuck   (zero_stuck),
    .period       (period),
    .period_valid (period_valid)
  );

  // Generator step: shift right, feedback b0^b1 into the MSB.
  function automatic int nxt(input int p);
    return (p >> 1) | (((p ^ (p >> 1)) & 1) << 3);
  endfunction

  function automatic logic [16:0] obs();
    return {locked, mismatch, err_count, zero_stuck, period, period_valid};
  endfunction

  function automatic logic [16:0] expv();
    logic [7:0] e;
    logic [4:0] p;
    e = m_err[7:0];
    p = m_per[4:0];
    return {m_lock, m_mis, e, m_zero, p, m_pv};
  endfunction

  function automatic int wrong_val(input int p);
    int v;
    v = nxt(p);
    while (v == nxt(p) || v == 0) v = int'($urandom_range(1, 15));
    return v;
  endfunction

  task automatic model_reset();
    m_acq = 1; m_lock = 0; m_mis = 0; m_zero = 0; m_pv = 0;
    m_prev = 0; m_match = 0; m_miss = 0; m_err = 0;
    m_per = 0; m_ref = 0; m_pcnt = 0;
  endtask

  task automatic model(input bit e, input int v, input bit c);
    bit was;
    int p;
    m_mis = 0;
    m_pv = 0;
    if (c) begin
      m_err = 0; m_acq = 1; m_lock = 0; m_match = 0; m_miss = 0;
      return;
    end
    if (!e) return;
    was = m_lock;
    if (m_acq) begin
      m_prev = v;
      m_zero = (v == 0);
      if (v != 0) begin m_acq = 0; m_match = 0; end
      return;
    end
    p = nxt(m_prev);
    m_prev = v;
    m_zero = (v == 0);
    if (v == 0) begin
      m_mis = 1;
      if (m_err < 255) m_err++;
      m_acq = 1;
      m_lock = 0;
    end else if (v == p) begin
      if (m_lock) m_miss = 0;
      else begin
        m_match++;
        if (m_match == LOCK_COUNT) begin m_lock = 1; m_miss = 0; end
      end
    end else begin
      m_mis = 1;
      if (m_err < 255) m_err++;
      if (m_lock) begin
        m_miss++;
        if (m_miss == LOSS_COUNT) begin m_lock = 0; m_match = 0; end
      end else m_match = 0;
    end
    if (PER_ON) begin
      if (!was && m_lock) begin
        m_ref = v;
        m_pcnt = 0;
      end else if (was && m_lock) begin
        m_pcnt++;
        if (v == m_ref || m_pcnt == 31) begin
          m_per = m_pcnt; m_pv = 1; m_pcnt = 0;
        end
      end
    end
  endtask

  task automatic drive(input bit e, input int v, input bit c);
    en = e;
    in_v = v[3:0];
    clear = c;
    @(posedge clk);
    #1;
    model(e, v, c);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    en = 1'b1;
    in_v = 4'b0101;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    n_cmp++;
    if (obs() !== 17'd0) begin
      n_bad++;
      $display("FAIL reset: got %h want %h", obs(), 17'd0);
    end
    reset = 1'b1;
  endtask

  task automatic test_lock();
    int seq [5] = '{8, 4, 2, 9, 12};
    for (int i = 0; i < 5; i++) begin
      drive(1, seq[i], 0);
      n_cmp++;
      if (obs() !== expv()) begin
        n_bad++;
        $display("FAIL lock_step%0d: got %h want %h", i, obs(), expv());
      end
      if (i == 3) begin
        n_cmp++;
        if (locked !== 1'b0) begin
          n_bad++;
          $display("FAIL lock_early: got %b want 0", locked);
        end
      end
    end
    n_cmp++;
    if (locked !== 1'b1 || err_count !== 8'd0) begin
      n_bad++;
      $display("FAIL lock_done: got %b/%0d want 1/0", locked, err_count);
    end
  endtask

  task automatic test_single_error();
    drive(1, 15, 0);
    n_cmp++;
    if (mismatch !== 1'b1 || err_count !== 8'd1 || locked !== 1'b1) begin
      n_bad++;
      $display("FAIL single_err: got %b/%0d/%b want 1/1/1",
               mismatch, err_count, locked);
    end
    for (int i = 0; i < 6; i++) begin
      drive(1, nxt(m_prev), 0);
      n_cmp++;
      if (obs() !== expv()) begin
        n_bad++;
        $display("FAIL resume%0d: got %h want %h", i, obs(), expv());
      end
    end
    n_cmp++;
    if (err_count !== 8'd1 || locked !== 1'b1) begin
      n_bad++;
      $display("FAIL resume_end: got %0d/%b want 1/1", err_count, locked);
    end
  endtask

  task automatic test_loss();
    for (int i = 0; i < 2; i++) begin
      drive(1, wrong_val(m_prev), 0);
      n_cmp++;
      if (obs() !== expv()) begin
        n_bad++;
        $display("FAIL loss_miss%0d: got %h want %h", i, obs(), expv());
      end
    end
    n_cmp++;
    if (locked !== 1'b0 || err_count !== 8'd3) begin
      n_bad++;
      $display("FAIL loss_drop: got %b/%0d want 0/3", locked, err_count);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1, nxt(m_prev), 0);
      n_cmp++;
      if (locked !== (i == 3)) begin
        n_bad++;
        $display("FAIL relock%0d: got %b want %b", i, locked, i == 3);
      end
    end
  endtask

  task automatic test_zero();
    drive(1, 0, 0);
    n_cmp++;
    if (mismatch !== 1'b1 || zero_stuck !== 1'b1 || locked !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_hit: got %b/%b/%b want 1/1/0",
               mismatch, zero_stuck, locked);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0);
      n_cmp++;
      if (obs() !== expv() || mismatch !== 1'b0) begin
        n_bad++;
        $display("FAIL zero_rep%0d: got %h want %h", i, obs(), expv());
      end
    end
    drive(1, 6, 0);
    n_cmp++;
    if (zero_stuck !== 1'b0 || mismatch !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_exit: got %b/%b want 0/0", zero_stuck, mismatch);
    end
  endtask

  task automatic test_saturate();
    drive(1, 3, 1);
    drive(1, 3, 0);
    for (int i = 0; i < 300; i++) begin
      drive(1, wrong_val(m_prev), 0);
      n_cmp++;
      if (obs() !== expv()) begin
        n_bad++;
        $display("FAIL sat%0d: got %h want %h", i, obs(), expv());
      end
    end
    n_cmp++;
    if (err_count !== 8'd255) begin
      n_bad++;
      $display("FAIL sat_hold: got %0d want 255", err_count);
    end
    drive(1, 5, 1);
    n_cmp++;
    if (err_count !== 8'd0 || locked !== 1'b0 || mismatch !== 1'b0) begin
      n_bad++;
      $display("FAIL clear: got %0d/%b/%b want 0/0/0",
               err_count, locked, mismatch);
    end
    drive(1, wrong_val(m_prev), 0);
    n_cmp++;
    if (mismatch !== 1'b0 || obs() !== expv()) begin
      n_bad++;
      $display("FAIL clear_acq: got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_period();
    int pulses;
    int want;
    pulses = 0;
    drive(1, 1, 1);
    drive(1, 8, 0);
    for (int i = 0; i < 4; i++) drive(1, nxt(m_prev), 0);
    for (int i = 0; i < 45; i++) begin
      while ($urandom_range(0, 9) < 3) begin
        drive(0, int'($urandom_range(0, 15)), 0);
        n_cmp++;
        if (obs() !== expv()) begin
          n_bad++;
          $display("FAIL per_gap: got %h want %h", obs(), expv());
        end
      end
      drive(1, nxt(m_prev), 0);
      n_cmp++;
      if (obs() !== expv()) begin
        n_bad++;
        $display("FAIL per_step%0d: got %h want %h", i, obs(), expv());
      end
      if (period_valid === 1'b1) begin
        pulses++;
        n_cmp++;
        if (period !== 5'd15) begin
          n_bad++;
          $display("FAIL per_value: got %0d want 15", period);
        end
      end
    end
    want = PER_ON ? 3 : 0;
    n_cmp++;
    if (pulses != want) begin
      n_bad++;
      $display("FAIL per_pulses: got %0d want %0d", pulses, want);
    end
  endtask

  task automatic test_random();
    int r;
    int v;
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 85) v = nxt(m_prev);
      else if (r < 94) v = int'($urandom_range(0, 15));
      else v = 0;
      r = int'($urandom_range(0, 99));
      drive(r >= 12, v, r >= 12 && r < 14);
      n_cmp++;
      if (obs() !== expv()) begin
        n_bad++;
        $display("FAIL rand%0d: got %h want %h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_async_reset();
    drive(1, 1, 1);
    drive(1, 8, 0);
    for (int i = 0; i < 6; i++) drive(1, nxt(m_prev), 0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if (obs() !== 17'd0) begin
      n_bad++;
      $display("FAIL async_rst: got %h want %h", obs(), 17'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(1, 7, 0);
    n_cmp++;
    if (obs() !== expv() || mismatch !== 1'b0 || locked !== 1'b0) begin
      n_bad++;
      $display("FAIL post_rst: got %h want %h", obs(), expv());
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lock();
    test_single_error();
    test_loss();
    test_zero();
    test_saturate();
    test_period();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/iiitb_rc_checker.md
# iiitb_rc_checker

Downstream sequence checker for the 4-bit ring/LFSR generator: it consumes the generator's `out` bus each enabled cycle, predicts the next value from the generator's feedback rule, and reports lock, mismatches and the all-zero lock-up state. An optional meter reports the sequence period. It sits directly after the generator in the test/BIST path and presents registered status to the control logic.

## Interface
- `LOCK_COUNT`, 4: consecutive correct predictions needed to enter LOCK (1..15).
- `LOSS_COUNT`, 2: consecutive mismatches in LOCK that drop back to TRACK (1..15).
- `ERR_W`, 8: width of the error counter.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low; all state cleared while low.
- `en`  in  1  sample `in` on this edge.
- `in`  in  4  generator output bus, bit order as the generator (`in[0]` is LSB).
- `clear`  in  1  synchronous clear: `err_count` to 0, FSM to ACQ; overrides `en`.
- `locked`  out  1  high while FSM is in LOCK.
- `mismatch`  out  1  one-cycle pulse per mismatched sample.
- `err_count`  out  ERR_W  saturating mismatch count.
- `zero_stuck`  out  1  last sample was 4'b0000.
- `period`  out  5  last measured period in samples.
- `period_valid`  out  1  one-cycle pulse when `period` updates.

## Operation
- Prediction from previous sample p: pred = {p[0]^p[1], p[3], p[2], p[1]}.
- `prev` register updated with `in` on every enabled sample (resync after mismatch).
- FSM states ACQ, TRACK, LOCK:
  - ACQ: on `en`, capture `prev`; if `in`==0 stay ACQ, else go TRACK with match_cnt=0. No compare.
  - TRACK: on `en`, `in`==pred increments match_cnt; reaching LOCK_COUNT goes to LOCK (miss_cnt=0). Mismatch: pulse, err++, match_cnt=0, stay TRACK.
  - LOCK: match clears miss_cnt. Mismatch: pulse, err++, miss_cnt++; reaching LOSS_COUNT goes to TRACK with match_cnt=0.
- Zero sample in TRACK or LOCK: counts as mismatch (pulse, err++) and forces ACQ.
- `zero_stuck` set on any enabled zero sample, cleared on first enabled nonzero sample.
- `err_count` saturates at 2^ERR_W-1; never wraps.
- `en` low: no state, counter or output change; pulses deassert.
- `clear` with `en`: clear wins, sample ignored, `prev` unchanged, no pulse.
- Reset: ACQ, `prev`=0, all counters 0, all outputs 0.

## Timing
- All outputs registered; effect of the sample taken at edge k is visible after edge k.
- Minimum lock latency: LOCK_COUNT+1 enabled samples (1 in ACQ, LOCK_COUNT matches).
- `mismatch`, `period_valid` high exactly one cycle per event.
- Reset asserted mid-operation: outputs drop to 0 asynchronously; first edge after release is treated as ACQ.

## Configuration
- `IIITB_RC_CHK_PERIOD_EN` defined: period meter built. On LOCK entry, the current sample is the reference; count enabled samples until the reference recurs, then load `period` and pulse `period_valid`, restart. Count saturating at 31 reports 31 and restarts. Leaving LOCK aborts the measurement; `period` holds its last value.
- Not defined: meter absent; `period` and `period_valid` tied to 0.

## Structure
- Package `iiitb_rc_pkg`: FSM state enum, `LFSR_W`=4 constant, `lfsr_next` function (prediction rule), period width constant.
- Sub-module `iiitb_rc_period`: the period meter, instantiated only under the macro.

## Test plan
- Reset low, then drive seed 4'b1000 and true sequence 0100, 0010, 1001, 1100 with `en`=1 → `locked` rises after 5th sample, `err_count`=0.
- Locked, inject one wrong value (1111 in place of 0110) → one `mismatch` pulse, `err_count`=1, `locked` stays 1; resume correct sequence from 1111 → no further errors.
- Locked, two consecutive wrong values (LOSS_COUNT=2) → `locked` falls after second; 4 correct samples later `locked` rises again.
- Drive 0000 while locked → `mismatch` pulse, `zero_stuck`=1, state ACQ, `locked`=0; repeated 0000 → no further errors.
- 300 forced mismatches with ERR_W=8 → `err_count` holds 255; `clear` → 0 and ACQ.
- Macro defined, lock on seed 1000 and run true sequence → `period`=15 with `period_valid` pulse every 15 samples; toggle `en` low for gaps → same result.
